cnt_seq_ctrl: RTL and testbench
===============================

Name: cnt_seq_ctrl

Overview:
Sequencing controller between the filtered button pulses (BTN_FLTR outputs) and the loadable up/down counter FSM. It turns single-cycle button events into LOAD/CE commands in manual mode, or autonomously steps the counter every RATE generator ticks in run mode. It also arbitrates simultaneous LOAD, manual-step and auto-step requests onto the counter's single command interface. It keeps a shadow copy of the counter value for status and limit detection.

Parameters:
WIDTH, 4, counter/data width
RATE, 8, GEN_CE ticks per auto step in RUN (legal range 1..2^RATE_W-1)
RATE_W, 8, width of internal tick divider

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous reset, active-high
TICK  in  1  one-cycle clock enable from CE generator
BTN_STEP  in  1  filtered one-cycle step request
BTN_LOAD  in  1  filtered one-cycle load request
BTN_RUN  in  1  filtered one-cycle run/stop toggle
DIR_SW  in  1  direction, 1=up
DAT_SW  in  WIDTH  load value
CNT_CE  out  1  one-cycle step command to counter
CNT_LOAD  out  1  one-cycle load command to counter
CNT_UP  out  1  direction to counter
CNT_DAT  out  WIDTH  load data to counter
RUN_O  out  1  1 while in RUN
SHADOW_O  out  WIDTH  controller's copy of counter value

Behaviour:
- Reset (async, RST=1): state IDLE; CNT_CE=0, CNT_LOAD=0, CNT_UP=0, CNT_DAT=0, RUN_O=0, SHADOW_O=0, divider=0.
- All outputs are registered. A command pulse appears exactly 1 cycle after its triggering input, and lasts 1 cycle.
- CNT_UP is a register loaded from DIR_SW every cycle. A step issued in cycle n uses DIR_SW sampled in cycle n-1.
- States:
  - IDLE: manual mode.
    - BTN_LOAD -> CNT_LOAD pulse; CNT_DAT<=DAT_SW; shadow<=DAT_SW.
    - BTN_STEP -> CNT_CE pulse; shadow +/-1 mod 2^WIDTH.
    - BTN_RUN -> RUN; divider<=0.
  - RUN: divider increments on each TICK.
    - On TICK with divider==RATE-1: auto-step (CNT_CE pulse, shadow +/-1), divider<=0.
    - BTN_STEP is ignored.
    - BTN_LOAD executes the load, clears the divider, and stays in RUN.
    - BTN_RUN -> IDLE; divider<=0; any auto-step due that cycle is dropped.
- Priority in the same cycle: LOAD > manual STEP > auto-step. The losing step is dropped, not queued.
- CNT_LOAD and CNT_CE are never both 1.
- BTN_RUN together with BTN_LOAD: the load executes and the state toggles.
- BTN_RUN together with BTN_STEP in IDLE: the step executes and the state goes to RUN.
- RATE=1: an auto-step on every TICK.
- TICK absent: the divider holds.
- Shadow wraps mod 2^WIDTH (0xF+1=0x0, 0x0-1=0xF), matching counter behaviour.
- The divider never exceeds RATE-1.
- RST asserted mid-pulse: the pulse is terminated immediately and all state returns to reset values.

Optional Feature:
Macro WRAP_STOP_EN.
- Defined: in RUN, an auto-step that would wrap the shadow (0xF going up, or 0x0 going down) is not issued. Instead the state goes to IDLE and RUN_O drops on the next cycle.
  - Manual steps in IDLE still wrap.
  - A load in RUN is unaffected.
- Undefined: auto-steps wrap freely and the controller stays in RUN.

Decomposition:
- Shared package cnt_seq_pkg:
  - state encoding: ST_IDLE=1'b0, ST_RUN=1'b1
  - default WIDTH, RATE, RATE_W constants
  - command enum for the arbitration result: CMD_NONE, CMD_LOAD, CMD_STEP
- One sub-module, tick_div: RATE_W-bit divider with clear, enable=TICK, and terminal-count output. Instantiated once.
- Arbitration and shadow logic stay in cnt_seq_ctrl.

Test Plan:
1. Reset, then DAT_SW=4'hA, BTN_LOAD pulse -> next cycle CNT_LOAD=1 for 1 cycle, CNT_DAT=4'hA, SHADOW_O=4'hA, CNT_CE=0.
2. IDLE, DIR_SW=0, SHADOW=0, BTN_STEP -> CNT_CE 1-cycle pulse, CNT_UP=0, SHADOW_O=4'hF.
3. RATE=3, BTN_RUN, TICK every 5 clocks, DIR_SW=1 -> CNT_CE 1 cycle after every 3rd TICK; 4 auto-steps take shadow 0->4; RUN_O=1.
4. In RUN, BTN_LOAD coincident with the terminal TICK -> only CNT_LOAD fires, no CNT_CE. Divider restarts, so the next step comes 3 TICKs later.
5. In RUN with shadow=4'hE, DIR_SW=1:
   - WRAP_STOP_EN defined -> one step to 4'hF, then at the next due step no CNT_CE and RUN_O=0.
   - WRAP_STOP_EN undefined -> steps wrap to 4'h0.
6. RST asserted asynchronously mid-run, during a CNT_CE pulse -> all outputs 0 immediately. After release, a TICK yields no step (state IDLE).

Source files
------------

// File: rtl/cnt_seq_pkg.sv
// Shared types and default constants for the counter sequencing controller.
package cnt_seq_pkg;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_RATE   = 8;
    localparam int DEF_RATE_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Result of arbitrating load, manual step and auto step in one cycle.
    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_LOAD = 2'd1,
        CMD_STEP = 2'd2
    } cmd_t;

endpackage

// File: rtl/cnt_seq_ctrl_if.sv
// Button/tick inputs and counter command outputs of cnt_seq_ctrl.
interface cnt_seq_ctrl_if #(
    parameter int WIDTH = cnt_seq_pkg::DEF_WIDTH
);
    logic             TICK;
    logic             BTN_STEP;
    logic             BTN_LOAD;
    logic             BTN_RUN;
    logic             DIR_SW;
    logic [WIDTH-1:0] DAT_SW;
    logic             CNT_CE;
    logic             CNT_LOAD;
    logic             CNT_UP;
    logic [WIDTH-1:0] CNT_DAT;
    logic             RUN_O;
    logic [WIDTH-1:0] SHADOW_O;

    // master drives the buttons and switches, slave is the controller
    modport master (
        output TICK, BTN_STEP, BTN_LOAD, BTN_RUN, DIR_SW, DAT_SW,
        input  CNT_CE, CNT_LOAD, CNT_UP, CNT_DAT, RUN_O, SHADOW_O
    );

    modport slave (
        input  TICK, BTN_STEP, BTN_LOAD, BTN_RUN, DIR_SW, DAT_SW,
        output CNT_CE, CNT_LOAD, CNT_UP, CNT_DAT, RUN_O, SHADOW_O
    );
endinterface

// File: rtl/cnt_seq_ctrl_tick_div.sv
// Tick divider: counts enabled ticks 0..RATE-1, flags the terminal tick and
// restarts; clear has priority over counting.
module tick_div #(
    parameter int RATE   = cnt_seq_pkg::DEF_RATE,
    parameter int RATE_W = cnt_seq_pkg::DEF_RATE_W
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam logic [RATE_W-1:0] LAST = RATE_W'(RATE - 1);

    logic [RATE_W-1:0] cnt;

    assign tc = en && (cnt == LAST);

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || tc) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + RATE_W'(1);
        end
    end
endmodule

// File: rtl/cnt_seq_ctrl.sv
// Sequencing controller: button events -> counter LOAD/CE commands, with an
// auto-stepping RUN mode. Optional macro WRAP_STOP_EN stops RUN instead of wrapping.
module cnt_seq_ctrl
    import cnt_seq_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int RATE   = DEF_RATE,
    parameter int RATE_W = DEF_RATE_W
) (
    input  logic           CLK,
    input  logic           RST,
    cnt_seq_ctrl_if.slave  bus
);
    state_t           state;
    state_t           state_nxt;
    cmd_t             cmd;
    logic             div_clr;
    logic             div_en;
    logic             auto_due;
    logic             cnt_ce_q;
    logic             cnt_load_q;
    logic             cnt_up_q;
    logic [WIDTH-1:0] cnt_dat_q;
    logic [WIDTH-1:0] shadow;

`ifdef WRAP_STOP_EN
    logic wrap_hit;
    assign wrap_hit = bus.DIR_SW ? (shadow == {WIDTH{1'b1}}) : (shadow == '0);
`endif

    assign div_en = bus.TICK && (state == ST_RUN);

    tick_div #(
        .RATE   (RATE),
        .RATE_W (RATE_W)
    ) u_tick_div (
        .clk (CLK),
        .rst (RST),
        .clr (div_clr),
        .en  (div_en),
        .tc  (auto_due)
    );

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        cmd       = CMD_NONE;
        state_nxt = state;
        div_clr   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                div_clr = 1'b1;
                if (bus.BTN_LOAD)      cmd = CMD_LOAD;
                else if (bus.BTN_STEP) cmd = CMD_STEP;
                if (bus.BTN_RUN)       state_nxt = ST_RUN;
            end
            ST_RUN: begin
                div_clr = bus.BTN_LOAD || bus.BTN_RUN;
                if (bus.BTN_LOAD) begin
                    cmd = CMD_LOAD;
                end else if (auto_due && !bus.BTN_RUN) begin
`ifdef WRAP_STOP_EN
                    if (wrap_hit) state_nxt = ST_IDLE;
                    else          cmd = CMD_STEP;
`else
                    cmd = CMD_STEP;
`endif
                end
                if (bus.BTN_RUN) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            cnt_ce_q   <= 1'b0;
            cnt_load_q <= 1'b0;
            cnt_up_q   <= 1'b0;
            cnt_dat_q  <= '0;
            shadow     <= '0;
        end else begin
            state      <= state_nxt;
            cnt_up_q   <= bus.DIR_SW;
            cnt_load_q <= (cmd == CMD_LOAD);
            cnt_ce_q   <= (cmd == CMD_STEP);
            // Shadow tracks the counter, wrapping mod 2^WIDTH like it does.
            unique case (cmd)
                CMD_LOAD: begin
                    cnt_dat_q <= bus.DAT_SW;
                    shadow    <= bus.DAT_SW;
                end
                CMD_STEP: shadow <= bus.DIR_SW ? shadow + WIDTH'(1) : shadow - WIDTH'(1);
                default: ;
            endcase
        end
    end

    assign bus.CNT_CE   = cnt_ce_q;
    assign bus.CNT_LOAD = cnt_load_q;
    assign bus.CNT_UP   = cnt_up_q;
    assign bus.CNT_DAT  = cnt_dat_q;
    assign bus.RUN_O    = (state == ST_RUN);
    assign bus.SHADOW_O = shadow;
endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Self-checking bench for cnt_seq_ctrl: directed scenarios plus random
// stimulus against a cycle-level behavioural model.
module tb_cnt_seq_ctrl;
    localparam int W    = 4;
    localparam int RATE = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    // reference model state
    bit       m_run;
    int       m_ticks;
    int       m_shadow;
    bit       e_ce, e_load, e_up;
    bit [3:0] e_dat;

    cnt_seq_ctrl_if #(.WIDTH(W)) bus ();

    cnt_seq_ctrl #(.WIDTH(W), .RATE(RATE), .RATE_W(8)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_ticks = 0; m_shadow = 0;
        e_ce = 0; e_load = 0; e_up = 0; e_dat = '0;
    endtask

    // Outputs expected after one clock edge with the given inputs.
    task automatic model_step(input bit tick, input bit step, input bit load,
                              input bit runb, input bit dir, input bit [3:0] dat);
        bit due;
        bit wrap;
        e_ce   = 0;
        e_load = 0;
        e_up   = dir;
        if (load) begin
            e_load   = 1;
            e_dat    = dat;
            m_shadow = dat;
        end
        if (!m_run) begin
            if (!load && step) begin
                e_ce     = 1;
                m_shadow = (m_shadow + (dir ? 1 : 15)) % 16;
            end
            m_ticks = 0;
            if (runb) m_run = 1;
        end else begin
            due  = tick && (m_ticks == RATE - 1);
            wrap = dir ? (m_shadow == 15) : (m_shadow == 0);
            if (tick) m_ticks = (m_ticks + 1) % RATE;
            if (load || runb) m_ticks = 0;
            if (runb) begin
                m_run = 0;
            end else if (due && !load) begin
`ifdef WRAP_STOP_EN
                if (wrap) m_run = 0;
                else begin
                    e_ce     = 1;
                    m_shadow = (m_shadow + (dir ? 1 : 15)) % 16;
                end
`else
                e_ce     = 1;
                m_shadow = (m_shadow + (dir ? 1 : 15)) % 16;
`endif
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".ce"},     32'(bus.CNT_CE),   32'(e_ce));
        check({tag, ".load"},   32'(bus.CNT_LOAD), 32'(e_load));
        check({tag, ".up"},     32'(bus.CNT_UP),   32'(e_up));
        check({tag, ".dat"},    32'(bus.CNT_DAT),  32'(e_dat));
        check({tag, ".run"},    32'(bus.RUN_O),    32'(m_run));
        check({tag, ".shadow"}, 32'(bus.SHADOW_O), 32'(m_shadow));
        check({tag, ".excl"},   32'(bus.CNT_CE & bus.CNT_LOAD), 32'd0);
    endtask

    // Drive one cycle of inputs (just after a posedge), clock it, check #1 after the edge.
    task automatic cycle(input string tag, input bit tick, input bit step, input bit load,
                         input bit runb, input bit dir, input bit [3:0] dat);
        bus.TICK = tick; bus.BTN_STEP = step; bus.BTN_LOAD = load;
        bus.BTN_RUN = runb; bus.DIR_SW = dir; bus.DAT_SW = dat;
        model_step(tick, step, load, runb, dir, dat);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic idle_cycles(input string tag, input int n, input bit dir);
        for (int i = 0; i < n; i++) cycle(tag, 0, 0, 0, 0, dir, 4'h0);
    endtask

    // Runs `n` ticks spaced `gap` clocks apart.
    task automatic ticks(input string tag, input int n, input int gap, input bit dir);
        for (int i = 0; i < n; i++) begin
            cycle(tag, 1, 0, 0, 0, dir, 4'h0);
            idle_cycles(tag, gap - 1, dir);
        end
    endtask

    initial begin
        bus.TICK = 0; bus.BTN_STEP = 0; bus.BTN_LOAD = 0; bus.BTN_RUN = 0;
        bus.DIR_SW = 0; bus.DAT_SW = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        rst = 0;
        @(posedge clk);
        #1;
        compare_all("post_reset");

        // 1: load in IDLE
        cycle("t1_load", 0, 0, 1, 0, 0, 4'hA);
        check("t1_cnt_dat", 32'(bus.CNT_DAT), 32'hA);
        check("t1_pulse", 32'(bus.CNT_LOAD), 32'd1);
        cycle("t1_after", 0, 0, 0, 0, 0, 4'h0);
        check("t1_pulse_end", 32'(bus.CNT_LOAD), 32'd0);

        // 2: step down from 0 wraps to F
        cycle("t2_zero", 0, 0, 1, 0, 0, 4'h0);
        cycle("t2_step", 0, 1, 0, 0, 0, 4'h0);
        check("t2_shadow", 32'(bus.SHADOW_O), 32'hF);
        check("t2_ce", 32'(bus.CNT_CE), 32'd1);
        idle_cycles("t2_idle", 1, 0);

        // 3: RUN, TICK every 5 clocks, 4 auto steps 0->4
        cycle("t3_zero", 0, 0, 1, 0, 1, 4'h0);
        cycle("t3_run", 0, 0, 0, 1, 1, 4'h0);
        ticks("t3_ticks", 12, 5, 1);
        check("t3_shadow", 32'(bus.SHADOW_O), 32'h4);
        check("t3_run_o", 32'(bus.RUN_O), 32'd1);

        // 4: load on the terminal tick wins, divider restarts
        ticks("t4_pre", 2, 2, 1);
        cycle("t4_coinc", 1, 0, 1, 0, 1, 4'h7);
        check("t4_no_ce", 32'(bus.CNT_CE), 32'd0);
        ticks("t4_post", 3, 2, 1);
        check("t4_shadow", 32'(bus.SHADOW_O), 32'h8);

        // 5: wrap behaviour in RUN from E going up
        cycle("t5_load", 0, 0, 1, 0, 1, 4'hE);
        ticks("t5_a", 3, 2, 1);
        check("t5_f", 32'(bus.SHADOW_O), 32'hF);
        ticks("t5_b", 3, 2, 1);
`ifdef WRAP_STOP_EN
        check("t5_stop_run", 32'(bus.RUN_O), 32'd0);
        check("t5_stop_shadow", 32'(bus.SHADOW_O), 32'hF);
        cycle("t5_rerun", 0, 0, 0, 1, 1, 4'h0);
`else
        check("t5_wrap_shadow", 32'(bus.SHADOW_O), 32'h0);
        check("t5_wrap_run", 32'(bus.RUN_O), 32'd1);
`endif

        // 6: async reset during a CE pulse
        ticks("t6_pre", 2, 1, 1);
        cycle("t6_pulse", 1, 0, 0, 0, 1, 4'h0);
        check("t6_ce_seen", 32'(bus.CNT_CE), 32'd1);
        #1 rst = 1;
        #1;
        model_reset();
        compare_all("t6_async");
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        cycle("t6_tick", 1, 0, 0, 0, 1, 4'h0);
        ticks("t6_ticks", 3, 1, 1);
        check("t6_no_step_shadow", 32'(bus.SHADOW_O), 32'h0);

        // random mix
        for (int i = 0; i < 1500; i++) begin
            cycle("rand",
                  ($urandom_range(0, 99) < 40),
                  ($urandom_range(0, 99) < 10),
                  ($urandom_range(0, 99) < 6),
                  ($urandom_range(0, 99) < 4),
                  ($urandom_range(0, 99) < 60),
                  4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
